sample_burst_feeder: RTL and testbench

SAMPLE_BURST_FEEDER -- requirements
Module: sample_burst_feeder

---
 rtl/sample_burst_feeder.sv | 170 +++++++++++++++++
 tb/tb_sample_burst_feeder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : sample_burst_feeder
// Purpose  : Buffers a free-running audio sample stream in a first-word-fall-
//            through FIFO. Each time a full burst of samples is buffered, it
//            starts one fixed-length AXI write burst through an external AXI
//            master, which writes into a ring buffer in memory.
// Ports    : ACLK, ARESETN            clock, async active-low reset
//            ENABLE                   allows new bursts to start
//            S_SAMPLE_VALID/DATA      sample strobe and word (no backpressure)
//            M_INIT_AXI_TXN           one-cycle burst start pulse to master
//            M_TXN_DONE, M_ERROR      master completion / error levels
//            M_WDATA_REQ, M_WDATA     master beat-consume strobe, head word
//            M_TARGET_ADDR            byte address of the current burst
//            FIFO_LEVEL               buffered word count
//            OVERFLOW, BURST_ERR      sticky drop / master error flags
//            BURST_COUNT              completed bursts (wraps)
//            BUSY                     a burst is in progress
// Revision : 1.0 - initial release
// ============================================================================
module sample_burst_feeder #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          BURST_LEN    = 16,
  parameter int          FIFO_DEPTH   = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          REGION_BYTES = 4096
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        ENABLE,
  input  logic                        S_SAMPLE_VALID,
  input  logic [DATA_WIDTH-1:0]       S_SAMPLE_DATA,
  output logic                        M_INIT_AXI_TXN,
  input  logic                        M_TXN_DONE,
  input  logic                        M_ERROR,
  input  logic                        M_WDATA_REQ,
  output logic [DATA_WIDTH-1:0]       M_WDATA,
  output logic [31:0]                 M_TARGET_ADDR,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERFLOW,
  output logic                        BURST_ERR,
  output logic [15:0]                 BURST_COUNT,
  output logic                        BUSY
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          BW        = $clog2(BURST_LEN);
  localparam logic [AW:0] LVL_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] LVL_BURST = (AW+1)'(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [31:0] ADDR_STEP = 32'(BURST_LEN * 4);
  localparam logic [31:0] ADDR_END  = BASE_ADDR + 32'(REGION_BYTES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    XFER      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level;
  state_t                state;
  logic [BW-1:0]         beat;
  logic                  done_q;
  logic                  pop;
  logic                  push;
  logic                  done_rise;
  logic [31:0]           addr_inc;
  logic [31:0]           next_addr;

  // Beats are only consumed while streaming; a request elsewhere is ignored.
  assign pop  = (state == XFER) && M_WDATA_REQ && (level != '0);
  // A full FIFO still accepts a sample if a word leaves in the same cycle.
  assign push = S_SAMPLE_VALID && ((level != LVL_FULL) || pop);

  // The master's done is a level that may still be high from the previous
  // burst, so only a low-to-high transition counts as completion.
  assign done_rise = M_TXN_DONE && !done_q;

  assign addr_inc  = M_TARGET_ADDR + ADDR_STEP;
  assign next_addr = (addr_inc == ADDR_END) ? BASE_ADDR : addr_inc;

  // Sample storage carries no reset: emptiness is tracked by the pointers.
  always_ff @(posedge ACLK) begin
    if (push) begin
      mem[wr_ptr] <= S_SAMPLE_DATA;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
      if (S_SAMPLE_VALID && !push) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

  assign FIFO_LEVEL = level;
  assign M_WDATA    = (level != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state          <= IDLE;
      beat           <= '0;
      done_q         <= 1'b0;
      M_INIT_AXI_TXN <= 1'b0;
      BUSY           <= 1'b0;
      M_TARGET_ADDR  <= BASE_ADDR;
      BURST_COUNT    <= '0;
      BURST_ERR      <= 1'b0;
    end else begin
      done_q <= M_TXN_DONE;
      case (state)
        IDLE: begin
          if (ENABLE && (level >= LVL_BURST)) begin
            state          <= START;
            M_INIT_AXI_TXN <= 1'b1;
            BUSY           <= 1'b1;
          end
        end
        START: begin
          M_INIT_AXI_TXN <= 1'b0;
          beat           <= '0;
          state          <= XFER;
        end
        XFER: begin
          if (pop) begin
            if (beat == LAST_BEAT) begin
              beat  <= '0;
              state <= WAIT_DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (done_rise) begin
            BURST_COUNT   <= BURST_COUNT + 1'b1;
            BURST_ERR     <= BURST_ERR | M_ERROR;
            M_TARGET_ADDR <= next_addr;
            BUSY          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_burst_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sample_burst_feeder
// Purpose  : Self-checking bench for sample_burst_feeder. A queue-based model
//            predicts every output each cycle; a small AXI-master stand-in
//            consumes beats and answers with done/error levels.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_burst_feeder;

  localparam int          DW    = 32;
  localparam int          BL    = 16;
  localparam int          FD    = 64;
  localparam int          RB    = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          SLOTS = RB / (BL * 4);

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        ENABLE;
  logic        S_SAMPLE_VALID;
  logic [31:0] S_SAMPLE_DATA;
  logic        M_INIT_AXI_TXN;
  logic        M_TXN_DONE;
  logic        M_ERROR;
  logic        M_WDATA_REQ;
  logic [31:0] M_WDATA;
  logic [31:0] M_TARGET_ADDR;
  logic [6:0]  FIFO_LEVEL;
  logic        OVERFLOW;
  logic        BURST_ERR;
  logic [15:0] BURST_COUNT;
  logic        BUSY;

  sample_burst_feeder #(
    .DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
    .BASE_ADDR(BASE), .REGION_BYTES(RB)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .ENABLE(ENABLE),
    .S_SAMPLE_VALID(S_SAMPLE_VALID), .S_SAMPLE_DATA(S_SAMPLE_DATA),
    .M_INIT_AXI_TXN(M_INIT_AXI_TXN), .M_TXN_DONE(M_TXN_DONE),
    .M_ERROR(M_ERROR), .M_WDATA_REQ(M_WDATA_REQ), .M_WDATA(M_WDATA),
    .M_TARGET_ADDR(M_TARGET_ADDR), .FIFO_LEVEL(FIFO_LEVEL),
    .OVERFLOW(OVERFLOW), .BURST_ERR(BURST_ERR),
    .BURST_COUNT(BURST_COUNT), .BUSY(BUSY)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];
  bit m_busy = 0, m_init = 0, m_stream = 0, m_wait = 0;
  bit m_done_prev = 0, m_ovf = 0, m_err = 0;
  int m_beats = 0, m_count = 0, m_slot = 0;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      mq.delete();
      m_busy = 0; m_init = 0; m_stream = 0; m_wait = 0;
      m_done_prev = 0; m_ovf = 0; m_err = 0;
      m_beats = 0; m_count = 0; m_slot = 0;
    end else begin
      bit do_pop, do_push, rise;
      do_pop  = m_stream && M_WDATA_REQ && (mq.size() > 0);
      do_push = S_SAMPLE_VALID && ((mq.size() < FD) || do_pop);
      if (S_SAMPLE_VALID && !do_push) m_ovf = 1;
      rise = M_TXN_DONE && !m_done_prev;
      m_done_prev = M_TXN_DONE;
      if (!m_busy) begin
        if (ENABLE && mq.size() >= BL) begin m_busy = 1; m_init = 1; end
      end else if (m_init) begin
        m_init = 0; m_stream = 1; m_beats = 0;
      end else if (m_stream) begin
        if (do_pop) m_beats++;
        if (m_beats == BL) begin m_stream = 0; m_wait = 1; end
      end else if (m_wait && rise) begin
        m_wait = 0; m_busy = 0;
        m_count = (m_count + 1) % 65536;
        m_err = m_err | M_ERROR;
        m_slot = (m_slot + 1) % SLOTS;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(S_SAMPLE_DATA);
    end
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int          init_pulses = 0;
  logic [31:0] addr_log[$];
  int          cyc = 0, last_init = -1000, min_gap = 1000000;

  always @(negedge ACLK) begin
    cyc++;
    chk("level", 32'(FIFO_LEVEL), 32'(mq.size()));
    chk("wdata", M_WDATA, (mq.size() > 0) ? mq[0] : 32'h0);
    chk("init", 32'(M_INIT_AXI_TXN), 32'(m_init));
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("count", 32'(BURST_COUNT), 32'(m_count));
    chk("addr", M_TARGET_ADDR, BASE + 32'(m_slot * BL * 4));
    chk("ovf", 32'(OVERFLOW), 32'(m_ovf));
    chk("berr", 32'(BURST_ERR), 32'(m_err));
    if (ARESETN && M_INIT_AXI_TXN) begin
      init_pulses++;
      addr_log.push_back(M_TARGET_ADDR);
      if (cyc - last_init < min_gap) min_gap = cyc - last_init;
      last_init = cyc;
    end
  end

  // ---------------- AXI master stand-in ----------------
  int m_phase = 0, m_issued = 0, m_cnt = 0;
  bit cfg_stray = 0, cfg_keep = 0, cfg_err = 0;
  int cfg_delay = 5;

  initial begin
    M_WDATA_REQ = 0; M_TXN_DONE = 0; M_ERROR = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        m_phase = 0; m_issued = 0; m_cnt = 0;
        M_WDATA_REQ = 0; M_TXN_DONE = 0; M_ERROR = 0;
      end else begin
        case (m_phase)
          0: begin
            M_WDATA_REQ = cfg_stray;
            if (M_INIT_AXI_TXN) begin m_phase = 2; m_issued = 0; end
          end
          2: begin
            if (m_issued == BL) begin M_WDATA_REQ = 0; m_cnt = 0; m_phase = 3; end
            else begin M_WDATA_REQ = 1; m_issued++; end
          end
          3: begin
            m_cnt++;
            if (m_cnt == cfg_delay - 1 && M_TXN_DONE) M_TXN_DONE = 0;
            if (m_cnt == cfg_delay) begin
              M_TXN_DONE = 1; M_ERROR = cfg_err; m_phase = 4;
            end
          end
          default: begin
            if (!cfg_keep) M_TXN_DONE = 0;
            M_ERROR = 0; m_phase = 0;
          end
        endcase
      end
    end
  end

  // Beat data as presented to the master on cycles it consumes a beat.
  logic [31:0] dlog[$];
  initial begin
    forever begin
      @(negedge ACLK);
      #3;
      if (ARESETN && m_phase == 2 && m_issued > 0 && M_WDATA_REQ) dlog.push_back(M_WDATA);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic feed(input int n, input int first, input int every);
    for (int i = 0; i < n; i++) begin
      S_SAMPLE_VALID = 1; S_SAMPLE_DATA = 32'(first + i);
      @(negedge ACLK);
      if (every > 1) begin
        S_SAMPLE_VALID = 0;
        repeat (every - 1) @(negedge ACLK);
      end
    end
    S_SAMPLE_VALID = 0;
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n = 0;
    while (!(m_count == target && !m_busy && !BUSY) && n < budget) begin
      @(negedge ACLK); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout count=%0d required=%0d", name, BURST_COUNT, target);
    end
  endtask

  task automatic wait_init(input int budget, input string name);
    int n = 0;
    while (!M_INIT_AXI_TXN && n < budget) begin @(negedge ACLK); n++; end
    checks++;
    if (!M_INIT_AXI_TXN) begin
      errors++;
      $display("FAIL %s init pulse actual=0 required=1 within %0d cycles", name, budget);
    end
  endtask

  task automatic check_log(input string name, input int first, input int n);
    chk({name, "_len"}, 32'(dlog.size()), 32'(n));
    for (int i = 0; i < n && i < dlog.size(); i++) chk(name, dlog[i], 32'(first + i));
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_level"}, 32'(FIFO_LEVEL), 32'd0);
    chk({name, "_wdata"}, M_WDATA, 32'd0);
    chk({name, "_init"}, 32'(M_INIT_AXI_TXN), 32'd0);
    chk({name, "_busy"}, 32'(BUSY), 32'd0);
    chk({name, "_count"}, 32'(BURST_COUNT), 32'd0);
    chk({name, "_addr"}, M_TARGET_ADDR, BASE);
    chk({name, "_ovf"}, 32'(OVERFLOW), 32'd0);
    chk({name, "_berr"}, 32'(BURST_ERR), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int pulses0;
    ARESETN = 0; ENABLE = 0; S_SAMPLE_VALID = 0; S_SAMPLE_DATA = 0;
    repeat (3) @(negedge ACLK);
    check_reset_vals("rst0");
    chk("rst0_model_level", 32'(mq.size()), 32'd0);
    ARESETN = 1;
    @(negedge ACLK);

    // One burst of 1..16, done 5 cycles after the last beat.
    ENABLE = 1; cfg_delay = 5;
    dlog.delete();
    feed(16, 1, 1);
    wait_count(1, 200, "t1");
    chk("t1_pulses", 32'(init_pulses), 32'd1);
    check_log("t1_data", 1, 16);
    chk("t1_count", 32'(BURST_COUNT), 32'd1);
    chk("t1_addr", M_TARGET_ADDR, 32'h40);
    chk("t1_model_addr", 32'(m_slot * BL * 4), 32'h40);
    chk("t1_berr", 32'(BURST_ERR), 32'd0);

    // Fill with ENABLE low: 70 samples, 6 dropped; stray requests ignored.
    ENABLE = 0;
    feed(70, 1, 1);
    chk("t2_level", 32'(FIFO_LEVEL), 32'd64);
    chk("t2_ovf", 32'(OVERFLOW), 32'd1);
    chk("t2_pulses", 32'(init_pulses), 32'd1);
    cfg_stray = 1;
    repeat (5) @(negedge ACLK);
    chk("t2_stray_level", 32'(FIFO_LEVEL), 32'd64);
    dlog.delete();
    ENABLE = 1;
    wait_count(5, 400, "t2");
    cfg_stray = 0;
    check_log("t2_data", 1, 64);
    chk("t2_level_end", 32'(FIFO_LEVEL), 32'd0);
    chk("t2_addr", M_TARGET_ADDR, 32'h140);

    // Ring wrap: run to 66 bursts total with slow sample arrival.
    cfg_delay = 2;
    feed(61 * BL, 5000, 2);
    wait_count(66, 500, "t3");
    chk("t3_addr_len", 32'(addr_log.size()), 32'd66);
    for (int k = 0; k < 66 && k < addr_log.size(); k++)
      chk("t3_addr_seq", addr_log[k], BASE + 32'((k % 64) * 64));
    if (addr_log.size() >= 65) begin
      chk("t3_addr_63", addr_log[63], 32'hFC0);
      chk("t3_addr_64", addr_log[64], 32'h000);
    end
    checks++;
    if (min_gap < BL + 3) begin
      errors++;
      $display("FAIL t3_min_gap actual=%0d required>=%0d", min_gap, BL + 3);
    end

    // Done held high into the next wait, then error on the real rise.
    cfg_delay = 5; cfg_keep = 1; cfg_err = 0;
    feed(16, 7000, 1);
    wait_count(67, 200, "t4a");
    chk("t4a_berr", 32'(BURST_ERR), 32'd0);
    cfg_keep = 0; cfg_err = 1;
    feed(16, 7100, 1);
    wait_count(68, 200, "t4b");
    chk("t4b_count", 32'(BURST_COUNT), 32'd68);
    chk("t4b_berr", 32'(BURST_ERR), 32'd1);
    cfg_err = 0;
    feed(16, 7200, 1);
    wait_count(69, 200, "t4c");
    chk("t4c_berr", 32'(BURST_ERR), 32'd1);
    chk("t4c_count", 32'(BURST_COUNT), 32'd69);

    ENABLE = 0;
    @(posedge ACLK); #1; ARESETN = 0;
    @(negedge ACLK);
    check_reset_vals("rst1");
    ARESETN = 1;
    @(negedge ACLK);

    // Full FIFO with sample arriving on every pop cycle.
    feed(64, 1000, 1);
    chk("t5_full", 32'(FIFO_LEVEL), 32'd64);
    chk("t5_ovf0", 32'(OVERFLOW), 32'd0);
    dlog.delete();
    ENABLE = 1;
    wait_init(10, "t5");
    @(negedge ACLK);
    ENABLE = 0;
    feed(16, 1064, 1);
    chk("t5_level", 32'(FIFO_LEVEL), 32'd64);
    chk("t5_ovf", 32'(OVERFLOW), 32'd0);
    wait_count(1, 100, "t5");
    check_log("t5_data", 1000, 16);
    chk("t5_level_end", 32'(FIFO_LEVEL), 32'd64);

    // Reset in the middle of a burst, after the 8th beat.
    ENABLE = 1;
    wait_init(10, "t6");
    repeat (8) @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESETN = 0;
    #1;
    check_reset_vals("rst2");
    dlog.delete();
    repeat (2) @(negedge ACLK);
    ARESETN = 1;
    pulses0 = init_pulses;
    feed(15, 2000, 1);
    repeat (3) @(negedge ACLK);
    chk("t6_no_early_pulse", 32'(init_pulses - pulses0), 32'd0);
    feed(1, 2015, 1);
    wait_count(1, 100, "t6");
    check_log("t6_data", 2000, 16);
    chk("t6_pulses", 32'(init_pulses - pulses0), 32'd1);
    chk("t6_addr", M_TARGET_ADDR, 32'h40);

    repeat (3) @(negedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
